// File: rtl/muldiv_if.sv
// Request/response bundle for the multiply/divide unit: operation request,
// MTHI/MTLO writes, status and the HI/LO result registers.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per RUN cycle, 32 steps.
module muldiv_ctrl (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  op_r;
  logic [4:0]  cnt;
  logic [31:0] acc;      // partial product high half / partial remainder
  logic [31:0] quo;      // multiplier being consumed / dividend becoming quotient
  logic [31:0] opb;      // multiplicand / divisor magnitude
  logic        neg_res;
  logic        neg_rem;
  logic        dz_r;
  logic [31:0] hi_r, lo_r;

  logic        is_div, is_signed, divzero;
  logic [32:0] add_s, sub_s;
  logic [31:0] acc_nx, quo_nx;
  logic [31:0] a_abs, b_abs;
  logic [63:0] prod, prod_neg;
  logic [31:0] fix_hi, fix_lo;

  assign is_div    = op_r[1];
  assign is_signed = op_r[0];
  assign divzero   = bus.op[1] && (bus.b == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = divzero ? DONE : PREP;
      PREP:    state_nx = RUN;
      RUN:     if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Restoring divide: the shifted remainder is < 2*divisor, so bit 32 of the
  // 33-bit difference is set exactly when the trial subtract underflows.
  always_comb begin
    add_s  = {1'b0, acc} + {1'b0, opb};
    sub_s  = {acc, quo[31]} - {1'b0, opb};
    acc_nx = acc;
    quo_nx = quo;
    if (is_div) begin
      if (!sub_s[32]) begin
        acc_nx = sub_s[31:0];
        quo_nx = {quo[30:0], 1'b1};
      end else begin
        acc_nx = {acc[30:0], quo[31]};
        quo_nx = {quo[30:0], 1'b0};
      end
    end else begin
      if (quo[0]) begin
        acc_nx = add_s[32:1];
        quo_nx = {add_s[0], quo[31:1]};
      end else begin
        acc_nx = {1'b0, acc[31:1]};
        quo_nx = {acc[0], quo[31:1]};
      end
    end
  end

  always_comb begin
    a_abs    = (is_signed && quo[31]) ? -quo : quo;
    b_abs    = (is_signed && opb[31]) ? -opb : opb;
    prod     = {acc, quo};
    prod_neg = -prod;
    fix_hi   = '0;
    fix_lo   = '0;
    if (is_div) begin
      fix_lo = neg_res ? -quo : quo;
      fix_hi = neg_rem ? -acc : acc;
    end else begin
      {fix_hi, fix_lo} = neg_res ? prod_neg : prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= '0;
      cnt     <= '0;
      acc     <= '0;
      quo     <= '0;
      opb     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_r    <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_r <= bus.wdata;
          if (bus.lo_we) lo_r <= bus.wdata;
          if (bus.start) begin
            op_r <= bus.op;
            quo  <= bus.a;
            opb  <= bus.b;
            dz_r <= divzero;
          end
        end
        PREP: begin
          quo     <= a_abs;
          opb     <= b_abs;
          acc     <= '0;
          cnt     <= '0;
          neg_res <= is_signed && (quo[31] ^ opb[31]);
          neg_rem <= is_signed && quo[31];
        end
        RUN: begin
          acc <= acc_nx;
          quo <= quo_nx;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          hi_r <= fix_hi;
          lo_r <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.dz   = (state == DONE) && dz_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
